// File: rtl/add_seq_pkg.sv
// Shared types and defaults for the multi-precision add/subtract sequencer.
//   add_seq_state_t : control FSM state encoding
//   DEF_CHUNK       : default width of the shared chunk adder
//   DEF_NCHUNK      : default number of chunks per operation
package add_seq_pkg;

    localparam int unsigned DEF_CHUNK  = 4;
    localparam int unsigned DEF_NCHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Request/response bundle for the multi-precision add/subtract sequencer.
//   in_valid/in_ready         : request handshake
//   in_a/in_b/in_cin/in_sub   : request payload (operands, carry/borrow in, op select)
//   out_valid/out_ready       : response handshake
//   out_sum/out_cout/out_ovf  : response payload (result, carry/no-borrow, signed overflow)
//   busy                      : engine occupied (RUN or DONE)
// master = requester/consumer side, slave = engine side.
interface multiword_add_sequencer_if
    import add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CHUNK * DEF_NCHUNK
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/CLA_adder.sv
// Purely combinational W-bit carry-look-ahead adder used as the shared chunk datapath.
//   a_i, b_i  : addends
//   cin_i     : carry in
//   sum_c_o   : a_i + b_i + cin_i, modulo 2^W
//   cout_c_o  : carry out of the top bit
module CLA_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_c_o,
    output logic         cout_c_o
);
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    // Each carry is a flat sum-of-products of generate/propagate terms, no ripple chain.
    always_comb begin
        logic acc;
        logic pp;
        p    = a_i ^ b_i;
        g    = a_i & b_i;
        c    = '0;
        c[0] = cin_i;
        acc  = 1'b0;
        pp   = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin_i);
        end
    end

    assign sum_c_o  = p ^ c[W-1:0];
    assign cout_c_o = c[W];
endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract engine: one CHUNK-bit CLA evaluates a WIDTH-bit
// A +/- B +/- cin one chunk per cycle, LSB chunk first, carrying between chunks.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of multiword_add_sequencer_if (request, response, busy)
module multiword_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned CHUNK  = DEF_CHUNK,
    parameter int unsigned NCHUNK = DEF_NCHUNK
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multiword_add_sequencer_if.slave    bus
);
    localparam int unsigned WIDTH = CHUNK * NCHUNK;
    localparam int unsigned CW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(NCHUNK - 1);

    add_seq_state_t   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [CHUNK-1:0] cla_sum;
    logic             cla_cout;

    // Shared chunk adder always works on the low chunk of the shifting operand registers.
    CLA_adder #(.W(CHUNK)) u_cla (
        .a_i      (a_q[CHUNK-1:0]),
        .b_i      (b_q[CHUNK-1:0]),
        .cin_i    (carry_q),
        .sum_c_o  (cla_sum),
        .cout_c_o (cla_cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    // Subtraction is A + ~B + ~borrow, so invert B and the incoming carry.
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_cin ^ bus.in_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < int'(NCHUNK); k++) begin
                    if (cnt_q == CW'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = cla_sum;
                    end
                end
                carry_d = cla_cout;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                if (cnt_q == LAST_K) begin
                    // Low-chunk top bits are the operand sign bits on the last chunk.
                    cout_d  = cla_cout;
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                              (cla_sum[CHUNK-1] != a_q[CHUNK-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            DONE: begin
                if (bus.out_ready && out_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the decoded next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer with CHUNK=4, NCHUNK=4.
module tb_multiword_add_sequencer;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = 4;
    localparam int unsigned WIDTH  = CHUNK * NCHUNK;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   cyc;
    bit   rand_ready;
    logic ov_prev;

    exp_t exp_q[$];
    int   acc_q[$];

    multiword_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

    multiword_add_sequencer #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [WIDTH:0] r;
        longint      sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            e.cout = ~r[WIDTH];
            sr     = sa - sb - longint'(cin);
        end else begin
            r      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            e.cout = r[WIDTH];
            sr     = sa + sb + longint'(cin);
        end
        e.sum = r[WIDTH-1:0];
        e.ovf = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one request and hold it until accepted; expected response goes to the scoreboard.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        int waited;
        waited       = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            exp_q.push_back(model(a, b, cin, sub));
            tick();
            acc_q.push_back(cyc);
        end
        bus.in_valid = 1'b0;
    endtask

    // Response monitor: latency on every rising out_valid, payload on every handshake.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1 && ov_prev !== 1'b1) begin
                if (acc_q.size() == 0) begin
                    check("latency_no_accept", 32'd1, 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 32'(cyc - a), 32'(NCHUNK));
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum",  32'(bus.out_sum),  32'(e.sum));
                    check("cout", 32'(bus.out_cout), 32'(e.cout));
                    check("ovf",  32'(bus.out_ovf),  32'(e.ovf));
                end
            end
        end
        ov_prev = bus.out_valid;
    end

    // Random response backpressure when enabled.
    always @(posedge clk) begin
        #2;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int waited;
        n_chk        = 0;
        n_fail       = 0;
        cyc          = 0;
        rand_ready   = 1'b0;
        ov_prev      = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_cin   = 1'b0;
        bus.in_sub   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out_sum",   32'(bus.out_sum),   32'd0);
        check("rst_out_cout",  32'(bus.out_cout),  32'd0);
        check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        rst_n = 1'b1;
        tick();

        // Carry ripple, signed overflow, subtraction with and without borrow.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("busy_in_run", 32'(bus.busy), 32'd1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h1234, 16'h0235, 1'b0, 1'b1);
        issue(16'h0000, 16'h0001, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h0000, 16'h0000, 1'b1, 1'b0);

        // Backpressure: hold DONE for three cycles while a new request waits.
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        bus.out_ready = 1'b0;
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("bp_reach_done", 32'(bus.out_valid), 32'd1);
        bus.in_a     = 16'h1111;
        bus.in_b     = 16'h2222;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_sum_held",  32'(bus.out_sum),   32'h1000);
            check("bp_cout_held", 32'(bus.out_cout),  32'd0);
            check("bp_valid",     32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_idle",  32'(bus.in_ready),  32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);

        // Reset while the third chunk is being computed discards the operation.
        issue(16'hABCD, 16'h1234, 1'b0, 1'b0);
        tick();
        tick();
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);

        // Randomised traffic with response stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            tick();
            waited++;
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
